counter_rr_scheduler: RTL and testbench



---
 rtl/counter_rr_scheduler.sv | 143 ++++++++++++++
 tb/tb_counter_rr_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_rr_scheduler.sv
// counter_rr_scheduler: round-robin arbiter that shares one start/ack-handshaked
// counter unit among NREQ requesters and returns a one-cycle done pulse to the
// served requester.
// Optional watchdog: define SCHED_TIMEOUT_EN to abort runs that exceed TIMEOUT
// cycles (err pulse); without it err is constant 0.
module counter_rr_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = $clog2(NREQ),
    parameter int unsigned TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] done,
    output logic            busy,
    output logic [IDW-1:0]  grant_id,
    output logic            err,
    output logic            cnt_start,
    output logic            cnt_ack,
    input  logic            cnt_irq_start,
    input  logic            cnt_irq_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] grant_next;
    logic [IDW-1:0] pick_id;
    logic [IDW-1:0] idx;
    logic           pick_found;
    logic           abort;

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_cnt;

    // Watchdog: cleared outside a run, counts every cycle of START/RUN/ACK
    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE || state == S_RELEASE) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WDW'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // Round-robin pick: first asserted request searching from ptr upward with wrap
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(ptr) + k) % NREQ);
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_id    = idx;
            end
        end
    end

    // Next-state, grant and pointer logic
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        grant_next = grant_id;
        abort      = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    state_next = S_START;
                    grant_next = pick_id;
                end
            end
            S_START: begin
                if (cnt_irq_start) begin
                    state_next = cnt_irq_done ? S_ACK : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_irq_done) begin
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                if (!cnt_irq_done) begin
                    state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_next = S_IDLE;
                ptr_next   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
`ifdef SCHED_TIMEOUT_EN
        // A run finishing normally on the limit cycle is not treated as an abort
        if ((state == S_START || state == S_RUN || state == S_ACK) &&
            wd_cnt == WDW'(TIMEOUT - 1) && state_next != S_RELEASE) begin
            state_next = S_RELEASE;
            abort      = 1'b1;
        end
`endif
    end

    // State register and registered outputs derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            grant_id  <= '0;
            done      <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            cnt_start <= 1'b0;
            cnt_ack   <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            grant_id  <= grant_next;
            done      <= (state_next == S_RELEASE) ? (NREQ'(1) << grant_next) : '0;
            busy      <= (state_next != S_IDLE);
            err       <= abort;
            cnt_start <= (state_next == S_START);
            cnt_ack   <= (state_next == S_ACK);
        end
    end

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Self-checking bench for counter_rr_scheduler: randomized request patterns,
// a responsive counter model, and a scoreboard of expected grants checked on
// every done pulse.
module tb_counter_rr_scheduler;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned TO   = 16;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] done;
    logic            busy;
    logic [IDW-1:0]  grant_id;
    logic            err;
    logic            cnt_start;
    logic            cnt_ack;
    logic            cnt_irq_start;
    logic            cnt_irq_done;

    int tests = 0;
    int fails = 0;
    bit model_en;
    int unsigned ptr_m;

    typedef struct {
        int unsigned idx;
        bit          err;
    } exp_t;

    exp_t exp_q[$];

    counter_rr_scheduler #(
        .NREQ   (NREQ),
        .IDW    (IDW),
        .TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .done         (done),
        .busy         (busy),
        .grant_id     (grant_id),
        .err          (err),
        .cnt_start    (cnt_start),
        .cnt_ack      (cnt_ack),
        .cnt_irq_start(cnt_irq_start),
        .cnt_irq_done (cnt_irq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference arbitration: first requester at or after the pointer, with wrap
    function automatic int unsigned rr_pick(input logic [NREQ-1:0] p, input int unsigned ptr);
        for (int k = 0; k < NREQ; k++) begin
            int unsigned i;
            i = (ptr + 32'(k)) % NREQ;
            if (p[IDW'(i)]) return i;
        end
        return 0;
    endfunction

    // Present a request pattern and record the requester the model expects to win
    task automatic issue(input logic [NREQ-1:0] pat, input bit exp_err, input bit push,
                         output int unsigned e);
        exp_t x;
        req   = pat;
        e     = rr_pick(pat, ptr_m);
        ptr_m = (e + 1) % NREQ;
        x.idx = e;
        x.err = exp_err;
        if (push) exp_q.push_back(x);
    endtask

    // cnt_start and busy must rise one cycle after the request is sampled
    task automatic expect_start(input int unsigned e);
        @(negedge clk);
        chk("start_cnt_start", 32'(cnt_start), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_grant_id", 32'(grant_id), e);
    endtask

    // Wait for the done pulse, optionally scrambling req mid-run
    task automatic wait_done(input bit mutate);
        bit seen;
        int mut_at;
        seen   = 1'b0;
        mut_at = int'($urandom_range(0, 6));
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (done != '0) seen = 1'b1;
            else if (mutate && c == mut_at) req = NREQ'($urandom);
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: no done within 100 cycles at %0t", $time);
        end
    endtask

    // One full run entered from the negedge of a RELEASE (or idle) cycle
    task automatic run_one(input logic [NREQ-1:0] pat, input int gap, input bit mutate);
        int unsigned e;
        if (gap == 0) begin
            issue(pat, 1'b0, 1'b1, e);
            @(negedge clk);
            chk("gap_busy", 32'(busy), 32'd0);
        end else begin
            req = '0;
            @(negedge clk);
            chk("gap_busy", 32'(busy), 32'd0);
            repeat (gap - 1) @(negedge clk);
            issue(pat, 1'b0, 1'b1, e);
        end
        expect_start(e);
        wait_done(mutate);
    endtask

    // Counter model: answers cnt_start with irqStart, irqDone and irqDone release
    initial begin
        bit same;
        forever begin
            do @(negedge clk); while (!(cnt_start && model_en && !rst));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            same          = ($urandom_range(0, 3) == 0);
            cnt_irq_start = 1'b1;
            if (same) cnt_irq_done = 1'b1;
            @(negedge clk);
            cnt_irq_start = 1'b0;
            chk("irq_start_drops_cnt_start", 32'(cnt_start), 32'd0);
            if (same) begin
                chk("same_cycle_ack", 32'(cnt_ack), 32'd1);
            end else begin
                repeat ($urandom_range(0, 10)) @(negedge clk);
                cnt_irq_done = 1'b1;
                @(negedge clk);
                chk("irq_done_raises_ack", 32'(cnt_ack), 32'd1);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            cnt_irq_done = 1'b0;
            @(negedge clk);
            chk("ack_drops", 32'(cnt_ack), 32'd0);
        end
    end

    // Scoreboard monitor: every done pulse must match the next expected grant
    always @(negedge clk) begin
        if (!rst && done != '0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: done=%0b with nothing expected at %0t", done, $time);
            end else begin
                exp_t e;
                logic [NREQ-1:0] ev;
                e  = exp_q.pop_front();
                ev = NREQ'(1) << e.idx;
                chk("done_vec", 32'(done), 32'(ev));
                chk("done_grant_id", 32'(grant_id), e.idx);
                chk("done_busy", 32'(busy), 32'd1);
                chk("done_err", 32'(err), 32'(e.err));
            end
        end
    end

    // Hard stop against a hung simulation
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int unsigned e;
        logic [NREQ-1:0] pat;
        bit err_seen;
        rst           = 1'b1;
        req           = '1;
        cnt_irq_start = 1'b0;
        cnt_irq_done  = 1'b0;
        model_en      = 1'b1;
        ptr_m         = 0;
        repeat (2) @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cnt_start", 32'(cnt_start), 32'd0);
        chk("rst_cnt_ack", 32'(cnt_ack), 32'd0);

        // All requesting out of reset: order 0,1,2,3,0
        rst = 1'b0;
        issue('1, 1'b0, 1'b1, e);
        expect_start(e);
        wait_done(1'b0);
        repeat (4) run_one('1, 0, 1'b0);

        // Single requester, then a run whose req is disturbed mid-flight
        run_one(4'b0100, 1, 1'b0);
        run_one(4'b1110, 0, 1'b1);
        run_one(4'b1100, 0, 1'b0);

        // Randomized runs
        for (int n = 0; n < 40; n++) begin
            do pat = NREQ'($urandom); while (pat == '0);
            run_one(pat, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Stuck counter: never answers cnt_start
        req = '0;
        @(negedge clk);
        model_en = 1'b0;
`ifdef SCHED_TIMEOUT_EN
        issue(4'b0011, 1'b1, 1'b1, e);
        expect_start(e);
        err_seen = 1'b0;
        for (int c = 0; c < int'(TO) + 8 && !err_seen; c++) begin
            @(negedge clk);
            if (done != '0) begin
                err_seen = 1'b1;
                chk("timeout_cnt_start", 32'(cnt_start), 32'd0);
                chk("timeout_err_with_done", 32'(err), 32'd1);
            end
        end
        if (!err_seen) begin
            tests++;
            fails++;
            $display("FAIL timeout_abort: no abort within %0d cycles", TO + 8);
        end
`else
        issue(4'b0011, 1'b0, 1'b0, e);
        expect_start(e);
        err_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (err) err_seen = 1'b1;
        end
        chk("stuck_err_never", 32'(err_seen), 32'd0);
        chk("stuck_cnt_start", 32'(cnt_start), 32'd1);
        chk("stuck_busy", 32'(busy), 32'd1);
`endif

        // Reset applied mid-run clears everything
        rst = 1'b1;
        repeat (2) @(negedge clk);
        req = '0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cnt_start", 32'(cnt_start), 32'd0);
        chk("midrst_grant_id", 32'(grant_id), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
